// File: rtl/fp_add_seq_ctrl.sv
// Multi-cycle floating-point add/sub sequencer: swap -> align -> add/sub -> normalise,
// one shift per clock, with valid/ready handshakes and one operation in flight.
module fp_add_seq_ctrl #(
  parameter int MAN_W = 10,
  parameter int EXP_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic             a_sgn,
  input  logic [EXP_W-1:0] a_exp,
  input  logic [MAN_W-1:0] a_man,
  input  logic             b_sgn,
  input  logic [EXP_W-1:0] b_exp,
  input  logic [MAN_W-1:0] b_man,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             res_sgn,
  output logic [EXP_W-1:0] res_exp,
  output logic [MAN_W-1:0] res_man,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_SWAP, S_ALIGN, S_ADD, S_NORM, S_DONE
  } state_t;

  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [EXP_W-1:0] MAN_W_E = EXP_W'(MAN_W);

  state_t           state_q, state_d;
  logic             sub_q;
  logic             l_sgn, s_sgn;
  logic [EXP_W-1:0] l_exp, s_exp, d_q;
  logic [MAN_W-1:0] l_man, s_man;
  logic [MAN_W:0]   sum;
  logic [EXP_W-1:0] diff;
  logic             swap;
  logic             accept;

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign accept    = in_valid && in_ready;

  // Larger exponent wins; on equal exponents the larger mantissa wins, ties keep a.
  assign swap = (s_exp > l_exp) || ((s_exp == l_exp) && (s_man > l_man));
  assign diff = swap ? (s_exp - l_exp) : (l_exp - s_exp);
  assign sum  = sub_q ? ({1'b0, l_man} - {1'b0, s_man}) : ({1'b0, l_man} + {1'b0, s_man});

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: next state defaults to the current state so every path assigns it and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_SWAP;
      S_SWAP:  state_d = (diff == '0) ? S_ADD : S_ALIGN;
      S_ALIGN: if ((d_q > MAN_W_E) || (d_q == EXP_W'(1))) state_d = S_ADD;
      S_ADD:   state_d = S_NORM;
      S_NORM:  if (res_man[MAN_W-1] || (res_exp == '0)) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the operand working registers are always loaded on accept before use, so only the visible outputs are reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_sgn  <= 1'b0;
      res_exp  <= '0;
      res_man  <= '0;
      overflow <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (accept) begin
          l_sgn    <= a_sgn;
          l_exp    <= a_exp;
          l_man    <= a_man;
          s_sgn    <= b_sgn ^ op_sub;
          s_exp    <= b_exp;
          s_man    <= b_man;
          sub_q    <= a_sgn != (b_sgn ^ op_sub);
          overflow <= 1'b0;
        end
        S_SWAP: begin
          if (swap) begin
            l_sgn <= s_sgn;  l_exp <= s_exp;  l_man <= s_man;
            s_sgn <= l_sgn;  s_exp <= l_exp;  s_man <= l_man;
          end
          d_q     <= diff;
          res_sgn <= swap ? s_sgn : l_sgn;
        end
        S_ALIGN: begin
          if (d_q > MAN_W_E) s_man <= '0;
          else               s_man <= {1'b0, s_man[MAN_W-1:1]};
          d_q <= d_q - EXP_W'(1);
        end
        S_ADD: begin
          if (!sub_q && sum[MAN_W]) begin
            if (l_exp == EXP_MAX) begin
              overflow <= 1'b1;
              res_man  <= '1;
              res_exp  <= EXP_MAX;
            end else begin
              res_man <= sum[MAN_W:1];
              res_exp <= l_exp + EXP_W'(1);
            end
          end else if (sum == '0) begin
            res_sgn <= 1'b0;
            res_exp <= '0;
            res_man <= '0;
          end else begin
            res_man <= sum[MAN_W-1:0];
            res_exp <= l_exp;
          end
        end
        S_NORM: if (!res_man[MAN_W-1] && (res_exp != '0)) begin
          res_man <= {res_man[MAN_W-2:0], 1'b0};
          res_exp <= res_exp - EXP_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_seq_ctrl.sv
// Self-checking bench for fp_add_seq_ctrl: arithmetic reference model, per-cycle
// output compare, directed corner cases, backpressure, mid-operation reset, random ops.
module tb_fp_add_seq_ctrl;
  localparam int MAN_W = 10;
  localparam int EXP_W = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0, in_ready, op_sub = 1'b0;
  logic             a_sgn = 1'b0, b_sgn = 1'b0;
  logic [EXP_W-1:0] a_exp = '0, b_exp = '0;
  logic [MAN_W-1:0] a_man = '0, b_man = '0;
  logic             out_valid, out_ready = 1'b0;
  logic             res_sgn, overflow, busy;
  logic [EXP_W-1:0] res_exp;
  logic [MAN_W-1:0] res_man;

  fp_add_seq_ctrl #(.MAN_W(MAN_W), .EXP_W(EXP_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op_sub(op_sub),
    .a_sgn(a_sgn), .a_exp(a_exp), .a_man(a_man), .b_sgn(b_sgn), .b_exp(b_exp), .b_man(b_man),
    .out_valid(out_valid), .out_ready(out_ready), .res_sgn(res_sgn), .res_exp(res_exp),
    .res_man(res_man), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sgn; int exp; int man; int ovf; int lat;
  } res_t;

  int   checks = 0;
  int   errors = 0;
  int   edges  = 0;
  int   acc_edge = 0;
  logic have_cur = 1'b0;
  logic seen_valid = 1'b0;
  res_t cur;

  always @(posedge clk) edges <= edges + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain integer arithmetic over the add/sub rules.
  function automatic res_t model(input int as, input int ae, input int am,
                                 input int bs, input int be, input int bm, input int sub);
    res_t r;
    int eb, lsg, le, lm, se, sm, d, n, k, s, man, ex, sg, ov;
    eb = bs ^ sub;
    if (ae > be || (ae == be && am >= bm)) begin
      lsg = as; le = ae; lm = am; se = be; sm = bm;
    end else begin
      lsg = eb; le = be; lm = bm; se = ae; sm = am;
    end
    d  = le - se;
    n  = (d == 0) ? 0 : ((d > MAN_W) ? 1 : d);
    sm = (d > MAN_W) ? 0 : (sm >> d);
    s  = (as != eb) ? lm - sm : lm + sm;
    sg = lsg; ov = 0;
    if (as == eb && s >= (1 << MAN_W)) begin
      if (le == (1 << EXP_W) - 1) begin ov = 1; man = (1 << MAN_W) - 1; ex = le; end
      else begin man = s / 2; ex = le + 1; end
    end else if (s == 0) begin
      sg = 0; ex = 0; man = 0;
    end else begin
      man = s; ex = le;
    end
    k = 0;
    while (man < (1 << (MAN_W - 1)) && ex > 0) begin
      man = man * 2; ex = ex - 1; k++;
    end
    r.sgn = sg; r.exp = ex; r.man = man; r.ovf = ov; r.lat = 3 + n + k;
    return r;
  endfunction

  task automatic pin(input string name, input res_t r, input int sg, input int ex,
                     input int mn, input int ov, input int lat);
    check({name, " model sgn"}, r.sgn, sg);
    check({name, " model exp"}, r.exp, ex);
    check({name, " model man"}, r.man, mn);
    check({name, " model ovf"}, r.ovf, ov);
    check({name, " model lat"}, r.lat, lat);
  endtask

  // Per-cycle compare while an operation is in flight.
  always @(negedge clk) begin
    if (!rst && have_cur) begin
      if (out_valid) begin
        if (!seen_valid) begin
          check("latency", edges - acc_edge, cur.lat);
          seen_valid = 1'b1;
        end
        check("res_sgn", res_sgn, cur.sgn);
        check("res_exp", res_exp, cur.exp);
        check("res_man", res_man, cur.man);
        check("overflow", overflow, cur.ovf);
        check("in_ready in done", in_ready, 0);
      end else begin
        check("busy in flight", busy, 1);
        check("in_ready in flight", in_ready, 0);
      end
    end
  end

  task automatic run_op(input int as, input int ae, input int am, input int bs,
                        input int be, input int bm, input int sub, input int hold);
    int t;
    cur = model(as, ae, am, bs, be, bm, sub);
    @(negedge clk);
    check("in_ready idle", in_ready, 1);
    a_sgn = as[0]; a_exp = ae[EXP_W-1:0]; a_man = am[MAN_W-1:0];
    b_sgn = bs[0]; b_exp = be[EXP_W-1:0]; b_man = bm[MAN_W-1:0];
    op_sub = sub[0]; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a_exp = '1; b_man = '0; op_sub = ~op_sub;  // inputs must be ignored while busy
    acc_edge = edges; seen_valid = 1'b0; have_cur = 1'b1;
    t = 0;
    while (!out_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) begin
      check("out_valid timeout", 0, 1);
      have_cur = 1'b0;
      return;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("out_valid held", out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    have_cur = 1'b0;
  endtask

  initial begin
    pin("1+1",    model(0, 15, 512,  0, 15, 512,  0), 0, 16, 512,  0, 3);
    pin("4+1",    model(0, 17, 512,  0, 15, 512,  0), 0, 17, 640,  0, 5);
    pin("cancel", model(0, 12, 700,  0, 12, 700,  1), 0, 0,  0,    0, 3);
    pin("norm",   model(0, 10, 768,  0, 10, 512,  1), 0, 9,  512,  0, 4);
    pin("swap",   model(0, 11, 512,  1, 11, 768,  0), 1, 10, 512,  0, 4);
    pin("ovf",    model(0, 31, 1023, 0, 31, 1023, 0), 0, 31, 1023, 1, 3);
    pin("large",  model(0, 29, 897,  0, 2,  600,  0), 0, 29, 897,  0, 4);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst in_ready", in_ready, 1);
    check("rst out_valid", out_valid, 0);
    check("rst busy", busy, 0);
    check("rst overflow", overflow, 0);
    check("rst res_sgn", res_sgn, 0);
    check("rst res_exp", res_exp, 0);
    check("rst res_man", res_man, 0);

    run_op(0, 15, 512,  0, 15, 512,  0, 0);
    run_op(0, 17, 512,  0, 15, 512,  0, 1);
    run_op(0, 12, 700,  0, 12, 700,  1, 0);
    run_op(0, 10, 768,  0, 10, 512,  1, 0);
    run_op(0, 11, 512,  1, 11, 768,  0, 2);
    run_op(0, 31, 1023, 0, 31, 1023, 0, 0);
    run_op(0, 29, 897,  0, 2,  600,  0, 5);
    run_op(1, 0,  512,  1, 0,  513,  0, 0);
    run_op(0, 20, 600,  0, 10, 1023, 0, 0);

    // Reset in the middle of a long alignment.
    @(negedge clk);
    a_sgn = 1'b0; a_exp = 5'd20; a_man = 10'd512;
    b_sgn = 1'b0; b_exp = 5'd14; b_man = 10'd512;
    op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre-reset busy", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort in_ready", in_ready, 1);
    check("abort busy", busy, 0);
    check("abort res_man", res_man, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("abort out_valid", out_valid, 0);
    end

    for (int i = 0; i < 150; i++) begin
      int as, ae, am, bs, be, bm, sub, sel;
      as  = $urandom_range(0, 1);
      bs  = $urandom_range(0, 1);
      sub = $urandom_range(0, 1);
      ae  = ($urandom_range(0, 7) == 0) ? 31 : $urandom_range(0, 31);
      am  = 512 + $urandom_range(0, 511);
      sel = $urandom_range(0, 7);
      if (sel == 0) begin
        be = ae; bm = am;
      end else if (sel < 3) begin
        be = ae; bm = 512 + $urandom_range(0, 511);
      end else begin
        be = $urandom_range(0, 31); bm = 512 + $urandom_range(0, 511);
      end
      run_op(as, ae, am, bs, be, bm, sub, $urandom_range(0, 2));
    end

    @(negedge clk);
    check("final in_ready", in_ready, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
